mem_ctrler: RTL and testbench

Single-port memory controller that sequences the byte-wide RAM bus for whole-cache-line transfers. Two requesters share the bus: the instruction fetcher (line reads only) and the load/store buffer (line reads and dirty-line write-backs). The controller arbitrates round-robin, serialises each line into consecutive byte accesses, and returns one line per grant with a one-cycle ready pulse. Rob-bus flushes abort in-flight reads; write-backs always complete.

---
 rtl/mem_ctrler.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_ctrler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrler.sv
// -----------------------------------------------------------------------------
// mem_ctrler
//
// Single-port memory controller that moves whole cache lines over a byte-wide
// RAM bus. Two requesters share the bus: the instruction fetcher (line reads)
// and the load/store buffer (line reads and dirty-line write-backs). Requests
// are arbitrated round-robin in IDLE, each line is serialised into L
// consecutive byte accesses, and completion is signalled by a one-cycle ready
// pulse to the owner together with its line buffer.
//
// Ports
//   clk, rst                    clock (posedge) / asynchronous active-high reset
//   rdy                         global enable; 0 freezes every register
//   reset_from_rob_bus          misprediction flush (aborts reads only)
//   mem_din / mem_dout          RAM read data (1-cycle latency) / write data
//   mem_a, mem_wr               RAM byte address / 1 = write
//   valid_from_inst_fetcher     fetcher line-read request
//   addr_from_inst_fetcher      any address within the requested line
//   ready_to_inst_fetcher       one-cycle completion pulse
//   cache_line_to_inst_fetcher  returned line, byte k at bits [8k+7:8k]
//   valid_from_ls_buffer        load/store buffer request
//   rw_flag_from_ls_buffer      0 = read, 1 = write
//   addr_from_ls_buffer         any address within the target line
//   cache_line_from_ls_buffer   write data, byte k at bits [8k+7:8k]
//   ready_to_ls_buffer          one-cycle completion pulse
//   cache_line_to_ls_buffer     returned line (reads)
// -----------------------------------------------------------------------------
module mem_ctrler #(
  parameter int CACHE_LINE_WIDTH = 4,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     rdy,
  input  logic                                     reset_from_rob_bus,
  input  logic [7:0]                               mem_din,
  output logic [7:0]                               mem_dout,
  output logic [ADDR_WIDTH-1:0]                    mem_a,
  output logic                                     mem_wr,
  input  logic                                     valid_from_inst_fetcher,
  input  logic [ADDR_WIDTH-1:0]                    addr_from_inst_fetcher,
  output logic                                     ready_to_inst_fetcher,
  output logic [8*(1<<CACHE_LINE_WIDTH)-1:0]       cache_line_to_inst_fetcher,
  input  logic                                     valid_from_ls_buffer,
  input  logic                                     rw_flag_from_ls_buffer,
  input  logic [ADDR_WIDTH-1:0]                    addr_from_ls_buffer,
  input  logic [8*(1<<CACHE_LINE_WIDTH)-1:0]       cache_line_from_ls_buffer,
  output logic                                     ready_to_ls_buffer,
  output logic [8*(1<<CACHE_LINE_WIDTH)-1:0]       cache_line_to_ls_buffer
);

  localparam int LINE_BYTES = 1 << CACHE_LINE_WIDTH;
  localparam int LINE_BITS  = 8 * LINE_BYTES;
  localparam int CNT_W      = CACHE_LINE_WIDTH + 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CAP  = CNT_W'(LINE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_LSB} owner_e;

  state_e                    state;
  owner_e                    owner;
  owner_e                    last_owner;
  logic [ADDR_WIDTH-1:0]     base;
  logic [LINE_BITS-1:0]      wline;
  logic [LINE_BITS-1:0]      rline;
  logic [CNT_W-1:0]          counter;

  // ---------------------------------------------------------------------------
  // Arbitration and request mux
  // ---------------------------------------------------------------------------
  owner_e                    grant;
  logic                      accept;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic                      req_rw;
  logic [ADDR_WIDTH-1:0]     req_base;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant = OWN_IF;
    if (valid_from_inst_fetcher && valid_from_ls_buffer) begin
      // Tie: whoever did not own the bus last time wins.
      grant = (last_owner == OWN_IF) ? OWN_LSB : OWN_IF;
    end else if (valid_from_ls_buffer) begin
      grant = OWN_LSB;
    end
  end

  assign accept   = (state == IDLE) && !reset_from_rob_bus &&
                    (valid_from_inst_fetcher || valid_from_ls_buffer);
  assign req_addr = (grant == OWN_LSB) ? addr_from_ls_buffer : addr_from_inst_fetcher;
  assign req_rw   = (grant == OWN_LSB) && rw_flag_from_ls_buffer;
  assign req_base = req_addr & ~OFFSET_MASK;

  // ---------------------------------------------------------------------------
  // Byte indexing
  //   counter holds the index of the byte currently on mem_a. Read data lags
  //   the address by one cycle, so the byte captured is always counter-1.
  //   The low line-offset bits of base are zero, so OR-ing the index in can
  //   never carry into the line address.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]            cnt_p1;
  logic [CNT_W-1:0]            cnt_m1;
  logic [CACHE_LINE_WIDTH-1:0] next_idx;
  logic [CACHE_LINE_WIDTH-1:0] cap_idx;
  logic [LINE_BITS-1:0]        rline_next;

  assign cnt_p1   = counter + CNT_W'(1);
  assign cnt_m1   = counter - CNT_W'(1);
  assign next_idx = cnt_p1[CACHE_LINE_WIDTH-1:0];
  assign cap_idx  = cnt_m1[CACHE_LINE_WIDTH-1:0];

  always_comb begin
    rline_next = rline;
    rline_next[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  // ---------------------------------------------------------------------------
  // Sequencer: state, counters, bus outputs and line buffers, all registered.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                      <= IDLE;
      owner                      <= OWN_IF;
      last_owner                 <= OWN_LSB;
      base                       <= '0;
      counter                    <= '0;
      mem_a                      <= '0;
      mem_wr                     <= 1'b0;
      mem_dout                   <= '0;
      ready_to_inst_fetcher      <= 1'b0;
      ready_to_ls_buffer         <= 1'b0;
      // NOTE: the wide line buffers are reset on purpose: requesters may look
      // at the line outputs before the first completion and must see zeros.
      wline                      <= '0;
      rline                      <= '0;
      cache_line_to_inst_fetcher <= '0;
      cache_line_to_ls_buffer    <= '0;
    end else if (rdy) begin
      ready_to_inst_fetcher <= 1'b0;
      ready_to_ls_buffer    <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant;
            last_owner <= grant;
            base       <= req_base;
            wline      <= cache_line_from_ls_buffer;
            counter    <= '0;
            mem_a      <= req_base;
            mem_wr     <= req_rw;
            if (req_rw) begin
              mem_dout <= cache_line_from_ls_buffer[7:0];
            end
            state      <= req_rw ? WRITE : READ;
          end
        end

        READ: begin
          if (reset_from_rob_bus) begin
            // Abort: the partially assembled line is simply never published.
            state   <= IDLE;
            mem_wr  <= 1'b0;
            counter <= '0;
          end else begin
            if (counter != '0) begin
              rline <= rline_next;
            end
            if (counter == LAST_CAP) begin
              state <= DONE;
              if (owner == OWN_IF) begin
                cache_line_to_inst_fetcher <= rline_next;
                ready_to_inst_fetcher      <= 1'b1;
              end else begin
                cache_line_to_ls_buffer    <= rline_next;
                ready_to_ls_buffer         <= 1'b1;
              end
            end else begin
              counter <= cnt_p1;
              // Last address stays on the bus while the final byte returns.
              if (counter != LAST_BYTE) begin
                mem_a <= base | ADDR_WIDTH'(next_idx);
              end
            end
          end
        end

        WRITE: begin
          // Write-backs ignore the flush: dirty data must reach memory.
          if (counter == LAST_BYTE) begin
            mem_wr <= 1'b0;
            state  <= DONE;
            if (owner == OWN_IF) begin
              ready_to_inst_fetcher <= 1'b1;
            end else begin
              ready_to_ls_buffer    <= 1'b1;
            end
          end else begin
            counter  <= cnt_p1;
            mem_a    <= base | ADDR_WIDTH'(next_idx);
            mem_dout <= wline[{next_idx, 3'b000} +: 8];
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrler.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrler
//
// Bench for mem_ctrler with L = 16. A byte-wide RAM model sits on the bus
// (initial content byte[a] = a[7:0]); it shares the global rdy enable with the
// controller. A separate shadow memory holds the contents the bench expects,
// and a scoreboard queue receives one entry per transaction that must
// complete; a monitor pops it on each ready pulse and compares owner and line.
// -----------------------------------------------------------------------------
module tb_mem_ctrler;

  localparam int L = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         reset_from_rob_bus;
  logic [7:0]   mem_din;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         valid_if;
  logic [31:0]  addr_if;
  logic         ready_if;
  logic [127:0] line_if;
  logic         valid_lsb;
  logic         rw_lsb;
  logic [31:0]  addr_lsb;
  logic [127:0] wline_lsb;
  logic         ready_lsb;
  logic [127:0] line_lsb;

  mem_ctrler #(.CACHE_LINE_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .rdy                        (rdy),
    .reset_from_rob_bus         (reset_from_rob_bus),
    .mem_din                    (mem_din),
    .mem_dout                   (mem_dout),
    .mem_a                      (mem_a),
    .mem_wr                     (mem_wr),
    .valid_from_inst_fetcher    (valid_if),
    .addr_from_inst_fetcher     (addr_if),
    .ready_to_inst_fetcher      (ready_if),
    .cache_line_to_inst_fetcher (line_if),
    .valid_from_ls_buffer       (valid_lsb),
    .rw_flag_from_ls_buffer     (rw_lsb),
    .addr_from_ls_buffer        (addr_lsb),
    .cache_line_from_ls_buffer  (wline_lsb),
    .ready_to_ls_buffer         (ready_lsb),
    .cache_line_to_ls_buffer    (line_lsb)
  );

  always #5 clk = ~clk;

  // RAM on the bus: data for the address of cycle c appears in cycle c+1.
  logic [7:0] ram   [0:65535];
  logic [7:0] model [0:65535];

  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         owner;    // 0 fetcher, 1 load/store buffer
    logic [127:0] exp_line;
  } sb_t;

  sb_t          sb_q[$];
  logic [127:0] last_line [2];

  typedef struct {
    logic         owner;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] wline;
    int           flush_at;    // active cycle in which the flush is pulsed
    int           freeze_at;   // active cycle after which rdy drops for 5 cycles
    int           idle_flush;  // cycles the flush suppresses acceptance
    logic [127:0] exp_line;    // expected returned line for reads
  } vec_t;

  function automatic logic [127:0] model_line(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  b;
    l = '0;
    for (int k = 0; k < L; k++) begin
      b = (a & 32'hFFFF_FFF0) + 32'(k);
      l = l | ({120'b0, model[b[15:0]]} << (8 * k));
    end
    return l;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [127:0] l);
    logic [31:0]  b;
    logic [127:0] t;
    for (int k = 0; k < L; k++) begin
      b = (a & 32'hFFFF_FFF0) + 32'(k);
      t = l >> (8 * k);
      model[b[15:0]] = t[7:0];
    end
  endfunction

  function automatic logic [127:0] pat_line(input logic [7:0] seed);
    logic [127:0] l;
    logic [7:0]   v;
    l = '0;
    for (int k = 0; k < L; k++) begin
      v = seed + 8'(k * 37);
      l = l | ({120'b0, v} << (8 * k));
    end
    return l;
  endfunction

  function automatic vec_t mk(input logic owner, input logic rw, input logic [31:0] addr,
                              input logic [127:0] wline, input int flush_at,
                              input int freeze_at, input int idle_flush);
    vec_t v;
    v.owner = owner; v.rw = rw; v.addr = addr; v.wline = wline;
    v.flush_at = flush_at; v.freeze_at = freeze_at; v.idle_flush = idle_flush;
    v.exp_line = '0;
    if (rw) model_write(addr, wline);
    else    v.exp_line = model_line(addr);
    return v;
  endfunction

  task automatic sb_push(input logic owner, input logic rw, input logic [127:0] line);
    sb_t e;
    e.owner = owner;
    if (!rw) last_line[owner] = line;
    e.exp_line = last_line[owner];   // a write leaves the owner's line untouched
    sb_q.push_back(e);
  endtask

  // Monitor: one ready at a time, never back to back, in scoreboard order.
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (ready_if || ready_lsb) begin
        check("ready_not_both", ready_if && ready_lsb, 0);
        check("ready_not_back_to_back", prev_ready, 0);
        if (sb_q.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("ready_owner", ready_lsb, e.owner);
          check("returned_line", e.owner ? line_lsb : line_if, e.exp_line);
        end
      end
      prev_ready = ready_if || ready_lsb;
    end
  end

  // ---------------------------------------------------------------------------
  // One full transaction from IDLE, checked cycle by cycle on the bus.
  // Called at #1 after an edge with the controller in IDLE; returns the same.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input vec_t v);
    logic [31:0]  base;
    logic [31:0]  a_hold;
    logic [127:0] t;
    logic         who_rdy;
    logic         other_rdy;
    int           lat;
    base = v.addr & 32'hFFFF_FFF0;
    lat  = v.rw ? L + 1 : L + 2;
    sb_push(v.owner, v.rw, v.exp_line);
    if (v.owner) begin
      valid_lsb = 1'b1; rw_lsb = v.rw; addr_lsb = v.addr; wline_lsb = v.wline;
    end else begin
      valid_if = 1'b1; addr_if = v.addr;
    end
    if (v.idle_flush > 0) begin
      reset_from_rob_bus = 1'b1;
      a_hold = mem_a;
      repeat (v.idle_flush) begin
        @(posedge clk); #1;
        check("idle_flush_no_accept_a", mem_a, a_hold);
        check("idle_flush_no_accept_wr", mem_wr, 0);
      end
      reset_from_rob_bus = 1'b0;
    end
    for (int n = 1; n <= lat; n++) begin
      @(posedge clk); #1;
      reset_from_rob_bus = (n == v.flush_at);
      if (n <= L) begin
        check("bus_addr", mem_a, base + 32'(n - 1));
        check("bus_wr", mem_wr, v.rw);
        if (v.rw) begin
          t = v.wline >> (8 * (n - 1));
          check("bus_dout", mem_dout, t[7:0]);
        end
      end else begin
        check("bus_wr_tail", mem_wr, 0);
      end
      who_rdy   = v.owner ? ready_lsb : ready_if;
      other_rdy = v.owner ? ready_if  : ready_lsb;
      check("ready_timing", who_rdy, n == lat);
      check("ready_other_low", other_rdy, 0);
      if (n == v.freeze_at) begin
        rdy = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check("freeze_addr_held", mem_a, base + 32'(n - 1));
        end
        rdy = 1'b1;
      end
    end
    reset_from_rob_bus = 1'b0;
    if (v.owner) valid_lsb = 1'b0; else valid_if = 1'b0;
    @(posedge clk); #1;
    check("ready_single_cycle", ready_if || ready_lsb, 0);
  endtask

  task automatic wait_ready(input logic who, input int max, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!(who ? ready_lsb : ready_if) && cnt < max);
    check("wait_ready_seen", who ? ready_lsb : ready_if, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  vec_t         tv [6];
  logic [127:0] spec_line;
  logic [127:0] arb_line;
  logic [127:0] ramp_1230;
  logic [31:0]  a_hold;
  logic         any_ready;
  int           cnt;

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram[a]   = 8'(a);
      model[a] = 8'(a);
    end
    last_line[0] = '0;
    last_line[1] = '0;
    spec_line = '0;
    for (int k = 0; k < L; k++) spec_line = spec_line | (128'(k) << (8 * k));
    arb_line  = pat_line(8'h91);
    ramp_1230 = 128'h3F3E3D3C3B3A39383736353433323130;

    // Vector table: expectations come from the shadow memory as it evolves.
    //          owner rw   addr           wline              flush freeze idle
    tv[0] = mk(1'b0, 1'b0, 32'h0000_1234, '0,                 0,    0,     0);
    tv[1] = mk(1'b1, 1'b1, 32'h0000_0200, spec_line,          0,    0,     0);
    tv[2] = mk(1'b1, 1'b1, 32'h0000_03F0, pat_line(8'h5A),    8,    0,     0);
    tv[3] = mk(1'b0, 1'b0, 32'h0000_03FF, '0,                 0,    0,     3);
    tv[4] = mk(1'b1, 1'b0, 32'h0000_03F7, '0,                 0,    6,     0);
    tv[5] = mk(1'b1, 1'b0, 32'hFFFF_FFFE, '0,                 0,    0,     0);
    tv[0].exp_line = ramp_1230;

    rst = 1'b1; rdy = 1'b1; reset_from_rob_bus = 1'b0; mem_din = '0;
    valid_if = 1'b0; addr_if = '0;
    valid_lsb = 1'b0; rw_lsb = 1'b0; addr_lsb = '0; wline_lsb = '0;

    #12;
    check("reset_mem_a", mem_a, 0);
    check("reset_mem_wr", mem_wr, 0);
    check("reset_mem_dout", mem_dout, 0);
    check("reset_ready_if", ready_if, 0);
    check("reset_ready_lsb", ready_lsb, 0);
    check("reset_line_if", line_if, 0);
    check("reset_line_lsb", line_lsb, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Both requesters valid from reset: fetcher, then LSB, then fetcher again.
    sb_push(1'b0, 1'b0, ramp_1230);
    sb_push(1'b1, 1'b1, '0);
    sb_push(1'b0, 1'b0, ramp_1230);
    model_write(32'h0000_0800, arb_line);
    valid_if = 1'b1; addr_if = 32'h0000_1234;
    valid_lsb = 1'b1; rw_lsb = 1'b1; addr_lsb = 32'h0000_0805; wline_lsb = arb_line;
    wait_ready(1'b0, 60, cnt);
    check("arb_first_if_latency", cnt, 18);
    wait_ready(1'b1, 60, cnt);
    check("arb_then_lsb_gap", cnt, 18);
    valid_lsb = 1'b0;
    wait_ready(1'b0, 60, cnt);
    check("arb_then_if_gap", cnt, 19);
    valid_if = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_txn(tv[i]);

    // Flush in cycle 8 of a fetcher read: back to IDLE, never a ready pulse.
    valid_if = 1'b1; addr_if = 32'h0000_4008;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      check("flush_read_addr", mem_a, 32'h0000_4000 + 32'(n - 1));
    end
    reset_from_rob_bus = 1'b1; valid_if = 1'b0;
    @(posedge clk); #1;
    reset_from_rob_bus = 1'b0;
    check("flush_read_wr", mem_wr, 0);
    a_hold = mem_a;
    any_ready = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ready_if || ready_lsb) any_ready = 1'b1;
    end
    check("flush_read_no_ready", any_ready, 0);
    check("flush_read_idle_addr", mem_a, a_hold);
    check("flush_keeps_if_line", line_if, last_line[0]);
    run_txn(mk(1'b0, 1'b0, 32'h0000_1235, '0, 0, 0, 0));

    // Asynchronous reset between edges in the middle of a write-back.
    valid_lsb = 1'b1; rw_lsb = 1'b1; addr_lsb = 32'h0000_5000; wline_lsb = pat_line(8'h33);
    repeat (6) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    check("midrst_mem_wr", mem_wr, 0);
    check("midrst_mem_a", mem_a, 0);
    check("midrst_mem_dout", mem_dout, 0);
    check("midrst_line_if", line_if, 0);
    check("midrst_ready", ready_if || ready_lsb, 0);
    valid_lsb = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    last_line[0] = '0;
    last_line[1] = '0;
    any_ready = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (ready_if || ready_lsb) any_ready = 1'b1;
    end
    check("midrst_no_ready", any_ready, 0);
    run_txn(mk(1'b1, 1'b0, 32'h0000_03F3, '0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
